// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue controller sitting in front of a clocked MIPS ALU. Takes one decoded
// instruction at a time over a valid/ready handshake. It maps opcode/funct to
// the 3-bit ALU op and selects operand B (rt register, or the extended
// immediate). It then drives the ALU, waits out the ALU's registered latency,
// captures the result plus a zero flag, and offers them downstream over
// valid/ready. Only one instruction is in flight at a time.
//
// Build option:
//   ILLEGAL_TRAP_EN  When defined, an illegal instruction is accepted but not
//                    issued to the ALU. The block goes straight to DONE with
//                    out_result=0, out_zero=1, out_err=1.
//                    When undefined, an illegal instruction decodes as ADD with
//                    B = rt, and out_err is tied to 0.
//
// Parameters:
//   W        datapath width of operands and result
//   ALU_LAT  edges from the ALU sampling its inputs to its result being stable
//            (minimum 1)
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          instruction handshake
//   in_opcode, in_funct        MIPS opcode and funct fields
//   in_rs_val, in_rt_val       register operand values
//   in_imm                     16-bit immediate
//   alu_rs, alu_rt, alu_op     registered operands and op to the ALU
//   alu_result                 registered result from the ALU
//   out_valid/out_ready        result handshake
//   out_result, out_zero       captured result and its zero flag
//   out_err                    illegal-instruction flag
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int W       = 32,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [5:0]   in_opcode,
  input  logic [5:0]   in_funct,
  input  logic [W-1:0] in_rs_val,
  input  logic [W-1:0] in_rt_val,
  input  logic [15:0]  in_imm,
  output logic [W-1:0] alu_rs,
  output logic [W-1:0] alu_rt,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_zero,
  output logic         out_err
);

  localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [W-1:0]       r_alu_rs;
  logic [W-1:0]       r_alu_rt;
  logic [2:0]         r_alu_op;
  logic [W-1:0]       r_result;
  logic               r_zero;

  logic               w_accept;
  logic               w_trap;
  logic               w_res_done;
  logic [2:0]         w_op;
  logic [W-1:0]       w_b;
  logic signed [15:0] w_imm_s;
  logic signed [W-1:0] w_imm_sx;
  logic [W-1:0]       w_imm_zx;
`ifdef ILLEGAL_TRAP_EN
  logic               w_legal;
  logic               r_err;
`endif

  // Immediate extension: a size cast of a signed value sign-extends.
  assign w_imm_s  = in_imm;
  assign w_imm_sx = W'(w_imm_s);
  assign w_imm_zx = W'(in_imm);

  // Instruction decode. Anything not listed falls back to ADD with B = rt.
  always_comb begin
    w_op = OP_ADD;
    w_b  = in_rt_val;
`ifdef ILLEGAL_TRAP_EN
    w_legal = 1'b1;
`endif
    case (in_opcode)
      6'b000000: begin
        case (in_funct)
          6'b100100: w_op = OP_AND;
          6'b100101: w_op = OP_OR;
          6'b100000: w_op = OP_ADD;
          6'b100010: w_op = OP_SUB;
          6'b101010: w_op = OP_SLT;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            w_legal = 1'b0;
`endif
          end
        endcase
      end
      6'b001000: begin w_op = OP_ADD; w_b = w_imm_sx; end
      6'b001010: begin w_op = OP_SLT; w_b = w_imm_sx; end
      6'b000100: begin w_op = OP_SUB; w_b = in_rt_val; end
      6'b001100: begin w_op = OP_AND; w_b = w_imm_zx; end
      6'b001101: begin w_op = OP_OR;  w_b = w_imm_zx; end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        w_legal = 1'b0;
`endif
      end
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign w_trap = ~w_legal;
`else
  assign w_trap = 1'b0;
`endif

  // rst gates in_ready so nothing is accepted on the reset edge.
  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign w_accept   = in_valid && in_ready;
  // The counter hits zero on this edge.
  assign w_res_done = (r_state == S_WAIT) && (r_cnt <= CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_trap ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_res_done) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage 0: ALU operands latched on accept. They are held until the next
  // issued instruction, so they stay stable while out_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_rs <= '0;
      r_alu_rt <= '0;
      r_alu_op <= OP_ADD;
    end else if (w_accept && !w_trap) begin
      r_alu_rs <= in_rs_val;
      r_alu_rt <= w_b;
      r_alu_op <= w_op;
    end
  end

  // Latency counter: loaded in ISSUE (the edge where the ALU samples),
  // then it counts down in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= CNT_W'(ALU_LAT);
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Stage 1: result capture. A trapped instruction loads the fixed error
  // response on the accept edge instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_accept && w_trap) begin
      r_result <= '0;
      r_zero   <= 1'b1;
    end else if (w_res_done) begin
      r_result <= alu_result;
      r_zero   <= (alu_result == '0);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_trap;
    end
  end
  assign out_err = r_err;
`else
  assign out_err = 1'b0;
`endif

  assign alu_rs     = r_alu_rs;
  assign alu_rt     = r_alu_rt;
  assign alu_op     = r_alu_op;
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_result;
  assign out_zero   = r_zero;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [5:0]  in_funct;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [15:0] in_imm;
  logic [31:0] alu_rs;
  logic [31:0] alu_rt;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_err;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        err;
    logic [2:0]  op;
    logic [31:0] b;
    logic        trap;
  } exp_t;

  typedef struct packed {
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
  } ins_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alu_issue_ctrl #(.W(32), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
    .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_op(alu_op),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_err(out_err)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'b000: return a & b;
      3'b001: return a | b;
      3'b010: return a + b;
      3'b011: return a - b;
      3'b100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Environment ALU with a one-edge registered latency.
  always @(posedge clk) alu_result <= alu_f(alu_rs, alu_rt, alu_op);

  function automatic exp_t model(input logic [5:0] opc, input logic [5:0] fn,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [15:0] imm);
    exp_t e;
    logic legal;
    legal  = 1'b1;
    e      = '0;
    e.op   = 3'b010;
    e.b    = rt;
    if (opc == 6'b000000) begin
      if      (fn == 6'b100100) e.op = 3'b000;
      else if (fn == 6'b100101) e.op = 3'b001;
      else if (fn == 6'b100000) e.op = 3'b010;
      else if (fn == 6'b100010) e.op = 3'b011;
      else if (fn == 6'b101010) e.op = 3'b100;
      else legal = 1'b0;
    end else if (opc == 6'b001000) begin e.op = 3'b010; e.b = {{16{imm[15]}}, imm}; end
    else if (opc == 6'b001010) begin e.op = 3'b100; e.b = {{16{imm[15]}}, imm}; end
    else if (opc == 6'b000100) begin e.op = 3'b011; e.b = rt; end
    else if (opc == 6'b001100) begin e.op = 3'b000; e.b = {16'h0000, imm}; end
    else if (opc == 6'b001101) begin e.op = 3'b001; e.b = {16'h0000, imm}; end
    else legal = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    if (!legal) begin
      e.trap = 1'b1; e.result = 32'd0; e.zero = 1'b1; e.err = 1'b1;
      return e;
    end
`else
    if (!legal) begin e.op = 3'b010; e.b = rt; end
`endif
    e.result = alu_f(rs, e.b, e.op);
    e.zero   = (e.result == 32'd0);
    e.err    = 1'b0;
    return e;
  endfunction

  // Present one instruction for a single edge (caller ensures IDLE) and record
  // the expected outcome.
  task automatic send(input logic [5:0] opc, input logic [5:0] fn,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
    in_opcode = opc; in_funct = fn; in_rs_val = rs; in_rt_val = rt; in_imm = imm;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    sb.push_back(model(opc, fn, rs, rt, imm));
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait_out(output int edges, output bit ok);
    edges = 0;
    ok    = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_funct = '0; in_rs_val = '0; in_rt_val = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (out_result !== 32'd0) $display("FAIL rst_out_result got=%h exp=0", out_result); else n_pass++;
    n_total++; if (out_zero !== 1'b0) $display("FAIL rst_out_zero got=%b exp=0", out_zero); else n_pass++;
    n_total++; if (out_err !== 1'b0) $display("FAIL rst_out_err got=%b exp=0", out_err); else n_pass++;
    n_total++; if (alu_rs !== 32'd0) $display("FAIL rst_alu_rs got=%h exp=0", alu_rs); else n_pass++;
    n_total++; if (alu_rt !== 32'd0) $display("FAIL rst_alu_rt got=%h exp=0", alu_rt); else n_pass++;
    n_total++; if (alu_op !== 3'b010) $display("FAIL rst_alu_op got=%b exp=010", alu_op); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL idle_out_valid got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_rtype_add();
    exp_t e; int edges; bit ok;
    out_ready = 1'b1;
    send(6'b000000, 6'b100000, 32'd5, 32'd7, 16'h0000);
    n_total++; if (alu_op !== 3'b010) $display("FAIL add_alu_op got=%b exp=010", alu_op); else n_pass++;
    n_total++; if (alu_rs !== 32'd5) $display("FAIL add_alu_rs got=%h exp=5", alu_rs); else n_pass++;
    n_total++; if (alu_rt !== 32'd7) $display("FAIL add_alu_rt got=%h exp=7", alu_rt); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL add_busy_in_ready got=%b exp=0", in_ready); else n_pass++;
    wait_out(edges, ok);
    n_total++; if (!ok || edges != LAT + 1) $display("FAIL add_latency got=%0d ok=%0d exp=%0d", edges, ok, LAT + 1); else n_pass++;
    e = sb.pop_front();
    n_total++; if (out_result !== e.result) $display("FAIL add_result got=%h exp=%h", out_result, e.result); else n_pass++;
    n_total++; if (out_zero !== 1'b0) $display("FAIL add_zero got=%b exp=0", out_zero); else n_pass++;
    n_total++; if (out_err !== 1'b0) $display("FAIL add_err got=%b exp=0", out_err); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL add_done_in_ready got=%b exp=0", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL add_post_valid got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL add_post_in_ready got=%b exp=1", in_ready); else n_pass++;
  endtask

  task automatic test_decode();
    ins_t tbl [8];
    exp_t e; int edges; bit ok;
    tbl[0] = '{6'b001000, 6'b000000, 32'd3,         32'h0,        16'hFFFD}; // addi -3
    tbl[1] = '{6'b001101, 6'b000000, 32'h1,         32'h0,        16'h8000}; // ori
    tbl[2] = '{6'b001100, 6'b000000, 32'hFFFFFFFF,  32'h0,        16'h8F0F}; // andi
    tbl[3] = '{6'b001010, 6'b000000, 32'hFFFFFFF0,  32'h0,        16'hFFFF}; // slti -16<-1
    tbl[4] = '{6'b000000, 6'b100010, 32'd10,        32'd3,        16'h0000}; // sub
    tbl[5] = '{6'b000000, 6'b101010, 32'd5,         32'hFFFFFFFF, 16'h0000}; // slt 5<-1
    tbl[6] = '{6'b000000, 6'b100100, 32'h0000F0F0,  32'h0000FF00, 16'h0000}; // and
    tbl[7] = '{6'b000000, 6'b100101, 32'h0000F0F0,  32'h00000F0F, 16'h1234}; // or
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].opc, tbl[i].fn, tbl[i].rs, tbl[i].rt, tbl[i].imm);
      e = sb[$];
      n_total++; if (alu_op !== e.op) $display("FAIL dec%0d_alu_op got=%b exp=%b", i, alu_op, e.op); else n_pass++;
      n_total++; if (alu_rt !== e.b) $display("FAIL dec%0d_alu_rt got=%h exp=%h", i, alu_rt, e.b); else n_pass++;
      wait_out(edges, ok);
      n_total++; if (!ok || edges != LAT + 1) $display("FAIL dec%0d_latency got=%0d ok=%0d exp=%0d", i, edges, ok, LAT + 1); else n_pass++;
      e = sb.pop_front();
      n_total++; if (out_result !== e.result) $display("FAIL dec%0d_result got=%h exp=%h", i, out_result, e.result); else n_pass++;
      n_total++; if (out_zero !== e.zero) $display("FAIL dec%0d_zero got=%b exp=%b", i, out_zero, e.zero); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    exp_t e; int edges; bit ok;
    out_ready = 1'b1;
    send(6'b000100, 6'b000000, 32'd9, 32'd9, 16'h0004);
    n_total++; if (alu_op !== 3'b011) $display("FAIL beq_alu_op got=%b exp=011", alu_op); else n_pass++;
    n_total++; if (alu_rt !== 32'd9) $display("FAIL beq_alu_rt got=%h exp=9", alu_rt); else n_pass++;
    wait_out(edges, ok);
    n_total++; if (!ok) $display("FAIL beq_timeout got=%0d exp=valid", edges); else n_pass++;
    e = sb.pop_front();
    n_total++; if (out_result !== e.result) $display("FAIL beq_result got=%h exp=%h", out_result, e.result); else n_pass++;
    n_total++; if (out_zero !== 1'b1) $display("FAIL beq_zero got=%b exp=1", out_zero); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e; int edges; bit ok;
    out_ready = 1'b0;
    send(6'b000000, 6'b100101, 32'hA5A50000, 32'h00005A5A, 16'h0000);
    wait_out(edges, ok);
    n_total++; if (!ok) $display("FAIL bp_timeout got=%0d exp=valid", edges); else n_pass++;
    e = sb.pop_front();
    // Second instruction waits on the bus while the first is stalled.
    in_opcode = 6'b000000; in_funct = 6'b100000;
    in_rs_val = 32'd111; in_rt_val = 32'd222; in_imm = 16'h0000;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_total++; if (out_valid !== 1'b1) $display("FAIL bp%0d_valid got=%b exp=1", i, out_valid); else n_pass++;
      n_total++; if (out_result !== e.result) $display("FAIL bp%0d_result got=%h exp=%h", i, out_result, e.result); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp%0d_in_ready got=%b exp=0", i, in_ready); else n_pass++;
      n_total++; if (alu_rs !== 32'hA5A50000) $display("FAIL bp%0d_alu_rs got=%h exp=a5a50000", i, alu_rs); else n_pass++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;  // output handshake edge; second must not be taken here
    n_total++; if (alu_rs !== 32'hA5A50000) $display("FAIL b2b_early_accept got=%h exp=a5a50000", alu_rs); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_valid_drop got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready got=%b exp=1", in_ready); else n_pass++;
    sb.push_back(model(6'b000000, 6'b100000, 32'd111, 32'd222, 16'h0000));
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++; if (alu_rs !== 32'd111) $display("FAIL b2b_alu_rs got=%h exp=6f", alu_rs); else n_pass++;
    wait_out(edges, ok);
    n_total++; if (!ok || edges != LAT + 1) $display("FAIL b2b_latency got=%0d ok=%0d exp=%0d", edges, ok, LAT + 1); else n_pass++;
    e = sb.pop_front();
    n_total++; if (out_result !== e.result) $display("FAIL b2b_result got=%h exp=%h", out_result, e.result); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    send(6'b000000, 6'b100000, 32'd20, 32'd22, 16'h0000);
    @(posedge clk); #1;  // now waiting on the ALU
    rst = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL mrst_in_ready got=%b exp=0", in_ready); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    n_total++; if (out_valid !== 1'b0) $display("FAIL mrst_valid got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (alu_op !== 3'b010) $display("FAIL mrst_alu_op got=%b exp=010", alu_op); else n_pass++;
    n_total++; if (alu_rs !== 32'd0) $display("FAIL mrst_alu_rs got=%h exp=0", alu_rs); else n_pass++;
    n_total++; if (out_result !== 32'd0) $display("FAIL mrst_result got=%h exp=0", out_result); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_total++; if (out_valid !== 1'b0) $display("FAIL mrst%0d_late_valid got=%b exp=0", i, out_valid); else n_pass++;
    end
    n_total++; if (in_ready !== 1'b1) $display("FAIL mrst_in_ready_after got=%b exp=1", in_ready); else n_pass++;
  endtask

  task automatic test_illegal();
    exp_t e; int edges; bit ok;
    logic [31:0] x_rs, x_rt; logic [2:0] x_op; int x_lat;
    out_ready = 1'b1;
    send(6'b000000, 6'b100101, 32'h30, 32'h0C, 16'h0000);
    wait_out(edges, ok);
    e = sb.pop_front();
    n_total++; if (out_result !== e.result) $display("FAIL ill_pre_result got=%h exp=%h", out_result, e.result); else n_pass++;
    @(posedge clk); #1;
    send(6'b111111, 6'b000000, 32'h100, 32'h23, 16'h1234);
    e = sb[$];
    // A trapped instruction leaves the ALU operands untouched and reports
    // right after the accepting edge.
    x_rs  = e.trap ? 32'h30 : 32'h100;
    x_rt  = e.trap ? 32'h0C : e.b;
    x_op  = e.trap ? 3'b001 : e.op;
    x_lat = e.trap ? 0 : LAT + 1;
    n_total++; if (alu_rs !== x_rs) $display("FAIL ill_alu_rs got=%h exp=%h", alu_rs, x_rs); else n_pass++;
    n_total++; if (alu_rt !== x_rt) $display("FAIL ill_alu_rt got=%h exp=%h", alu_rt, x_rt); else n_pass++;
    n_total++; if (alu_op !== x_op) $display("FAIL ill_alu_op got=%b exp=%b", alu_op, x_op); else n_pass++;
    wait_out(edges, ok);
    n_total++; if (!ok || edges != x_lat) $display("FAIL ill_latency got=%0d ok=%0d exp=%0d", edges, ok, x_lat); else n_pass++;
    e = sb.pop_front();
    n_total++; if (out_result !== e.result) $display("FAIL ill_result got=%h exp=%h", out_result, e.result); else n_pass++;
    n_total++; if (out_zero !== e.zero) $display("FAIL ill_zero got=%b exp=%b", out_zero, e.zero); else n_pass++;
    n_total++; if (out_err !== e.err) $display("FAIL ill_err got=%b exp=%b", out_err, e.err); else n_pass++;
    @(posedge clk); #1;
    // A legal instruction afterwards must clear the error flag.
    send(6'b000000, 6'b100000, 32'd1, 32'd1, 16'h0000);
    wait_out(edges, ok);
    e = sb.pop_front();
    n_total++; if (out_err !== 1'b0) $display("FAIL ill_err_clear got=%b exp=0", out_err); else n_pass++;
    n_total++; if (out_result !== e.result) $display("FAIL ill_post_result got=%h exp=%h", out_result, e.result); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype_add();
    test_decode();
    test_beq();
    test_back_to_back();
    test_mid_reset();
    test_illegal();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
